// File: rtl/attn_score_requant.sv
// attn_score_requant: scales QK^T score tiles by 1/sqrt(d_k) with round-half-up and saturation,
// and tracks the running per-row maximum so softmax can subtract it on the row's last tile.
module attn_score_requant #(
    parameter int WIDTH_IN    = 32,
    parameter int FRAC_IN     = 16,
    parameter int WIDTH_OUT   = 16,
    parameter int FRAC_OUT    = 8,
    parameter int BLOCK_SIZE  = 2,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH_IN-1:0]  in_data,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH_OUT-1:0] out_data,
    output logic                                     out_last,
    output logic                                     out_sat,
    output logic [BLOCK_SIZE*WIDTH_OUT-1:0]            out_row_max
);
    localparam int LANES = BLOCK_SIZE * BLOCK_SIZE;
    localparam int S     = FRAC_IN - FRAC_OUT + SCALE_SHIFT;
    localparam int TW    = WIDTH_IN + 1;
    localparam logic signed [TW-1:0] RND = {{(TW-1){1'b0}}, 1'b1} << (S - 1);
    localparam logic signed [TW-1:0] HI  = {{(TW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [TW-1:0] LO  = {{(TW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
    localparam logic signed [WIDTH_OUT-1:0] QMIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    localparam logic signed [WIDTH_OUT-1:0] QMAX = ~QMIN;

    if (S < 1) begin : g_bad_shift
        $error("attn_score_requant: FRAC_IN - FRAC_OUT + SCALE_SHIFT must be at least 1");
    end

    logic signed [TW-1:0]        rnd  [LANES];
    logic signed [TW-1:0]        s1   [LANES];
    logic signed [WIDTH_OUT-1:0] q    [LANES];
    logic signed [WIDTH_OUT-1:0] acc  [BLOCK_SIZE];
    logic signed [WIDTH_OUT-1:0] rmax [BLOCK_SIZE];
    logic v1, l1, ld1, ld2, sat_any;

    assign ld2      = !out_valid || out_ready;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        for (int k = 0; k < LANES; k++)
            rnd[k] = (TW'($signed(in_data[k*WIDTH_IN +: WIDTH_IN])) + RND) >>> S;
    end

    always_comb begin
        sat_any = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            q[k]    = s1[k] > HI ? QMAX : s1[k] < LO ? QMIN : s1[k][WIDTH_OUT-1:0];
            sat_any = sat_any || s1[k] > HI || s1[k] < LO;
        end
        for (int r = 0; r < BLOCK_SIZE; r++) begin
            rmax[r] = acc[r];
            for (int c = 0; c < BLOCK_SIZE; c++)
                rmax[r] = q[r*BLOCK_SIZE+c] > rmax[r] ? q[r*BLOCK_SIZE+c] : rmax[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            for (int k = 0; k < LANES; k++) s1[k] <= '0;
        end else if (ld1) begin
            v1 <= in_valid;
            l1 <= in_last;
            for (int k = 0; k < LANES; k++) s1[k] <= rnd[k];
        end
    end

    // The accumulator only moves on real beats, so bubbles never disturb a row group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_sat     <= 1'b0;
            out_row_max <= '0;
            for (int r = 0; r < BLOCK_SIZE; r++) acc[r] <= QMIN;
        end else if (ld2) begin
            out_valid <= v1;
            if (v1) begin
                out_last <= l1;
                out_sat  <= sat_any;
                for (int k = 0; k < LANES; k++) out_data[k*WIDTH_OUT +: WIDTH_OUT] <= q[k];
                for (int r = 0; r < BLOCK_SIZE; r++) begin
                    out_row_max[r*WIDTH_OUT +: WIDTH_OUT] <= l1 ? rmax[r] : '0;
                    acc[r] <= l1 ? QMIN : rmax[r];
                end
            end
        end
    end
endmodule

// File: tb/tb_attn_score_requant.sv
// tb_attn_score_requant: table vectors, hand-written stall/reset sequences and random back-pressure,
// all checked through an in-order scoreboard against a floor-division reference model.
module tb_attn_score_requant;
    localparam int WI = 32, WO = 16, B = 2, L = B * B, S = 9;
    localparam longint HALF = 64'sd1 <<< (S - 1), DIV = 64'sd1 <<< S;
    localparam longint QMAX = (64'sd1 <<< (WO - 1)) - 1, QMIN = -(64'sd1 <<< (WO - 1));
    localparam int NV = 10;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last, out_sat;
    logic [L*WI-1:0] in_data = '0;
    logic [L*WO-1:0] out_data;
    logic [B*WO-1:0] out_row_max;

    always #5 clk = ~clk;

    attn_score_requant dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sat(out_sat), .out_row_max(out_row_max)
    );

    typedef struct {
        logic [L*WO-1:0] data;
        logic            last;
        logic            sat;
        logic [B*WO-1:0] rmax;
    } exp_t;
    typedef struct {
        logic [L*WI-1:0] din;
        logic            last;
        exp_t            e;
    } vec_t;

    vec_t tbl [NV];
    exp_t sbq [$];
    exp_t cur_exp;
    bit use_model = 1'b0, stalled = 1'b0;
    int errs = 0, checks = 0, cyc = 0, nacc = 0, nfire = 0;
    int first_acc = -1, first_fire = -1, last_fire = -1;
    longint macc [B];
    logic [L*WO-1:0] snap_d;
    logic [B*WO-1:0] snap_r;
    logic snap_l, snap_s;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [L*WI-1:0] din, input logic last, input logic [L*WO-1:0] dout,
                                input logic sat, input logic [B*WO-1:0] rmax);
        vec_t v;
        v.din = din; v.last = last;
        v.e.data = dout; v.e.last = last; v.e.sat = sat; v.e.rmax = rmax;
        return v;
    endfunction

    // Reference: floor((x + 2^(S-1)) / 2^S), clip, then running row max with reset on last.
    function automatic exp_t model(input logic [L*WI-1:0] d, input logic last);
        exp_t e;
        longint t, m;
        longint qv [L];
        e.data = '0; e.rmax = '0; e.sat = 1'b0; e.last = last;
        for (int k = 0; k < L; k++) begin
            t = longint'($signed(d[k*WI +: WI])) + HALF;
            t = t >= 0 ? t / DIV : -((-t + DIV - 1) / DIV);
            if (t > QMAX) begin t = QMAX; e.sat = 1'b1; end
            else if (t < QMIN) begin t = QMIN; e.sat = 1'b1; end
            qv[k] = t;
            e.data[k*WO +: WO] = WO'(t);
        end
        for (int r = 0; r < B; r++) begin
            m = macc[r];
            for (int c = 0; c < B; c++) if (qv[r*B+c] > m) m = qv[r*B+c];
            if (last) begin e.rmax[r*WO +: WO] = WO'(m); macc[r] = QMIN; end
            else macc[r] = m;
        end
        return e;
    endfunction

    function automatic logic [WI-1:0] rand_lane();
        logic [WI-1:0] v;
        v = $urandom;
        return WI'($signed(v) >>> $urandom_range(0, 20));
    endfunction

    // One cycle: sample in the low phase, then cross the rising edge and return at the falling edge.
    task automatic tick();
        exp_t e;
        #1;
        chk("in_ready", in_ready, !(sbq.size() == 2 && !out_ready));
        if (stalled) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, snap_d);
            chk("stall_last", out_last, snap_l);
            chk("stall_sat", out_sat, snap_s);
            chk("stall_rowmax", out_row_max, snap_r);
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++; errs++;
                $display("FAIL unexpected_output: got beat data %h, required no output", out_data);
            end else begin
                e = sbq.pop_front();
                chk("data", out_data, e.data);
                chk("last", out_last, e.last);
                chk("sat", out_sat, e.sat);
                chk("row_max", out_row_max, e.rmax);
                nfire++;
                last_fire = cyc;
                if (first_fire < 0) first_fire = cyc;
            end
        end
        stalled = out_valid && !out_ready;
        snap_d = out_data; snap_l = out_last; snap_s = out_sat; snap_r = out_row_max;
        if (in_valid && in_ready) begin
            sbq.push_back(use_model ? model(in_data, in_last) : cur_exp);
            nacc++;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_data"}, out_data, '0);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_sat"}, out_sat, 1'b0);
        chk({tag, "_rowmax"}, out_row_max, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk({32'h00000300, 32'h000002FF, 32'h00000200, 32'h00010000}, 1'b1,
                    {16'h0002, 16'h0001, 16'h0001, 16'h0080}, 1'b0, {16'h0002, 16'h0080});
        tbl[1] = mk({32'h00000000, 32'hFFFFFD00, 32'h80000000, 32'h01000000}, 1'b1,
                    {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF}, 1'b1, {16'h0000, 16'h7FFF});
        tbl[2] = mk({32'hFFFFFE00, 32'hFFFFFE00, 32'h00000000, 32'h00000A00}, 1'b0,
                    {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0005}, 1'b0, 32'h0);
        tbl[3] = mk({32'hFFFFFE00, 32'hFFFFFE00, 32'h00000000, 32'h00001200}, 1'b0,
                    {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0009}, 1'b0, 32'h0);
        tbl[4] = mk({32'hFFFFFE00, 32'hFFFFFE00, 32'h00000000, 32'h00000600}, 1'b1,
                    {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0003}, 1'b0, {16'hFFFF, 16'h0009});
        tbl[5] = mk({32'h00000200, 32'h00000000, 32'h00000000, 32'h00000400}, 1'b1,
                    {16'h0001, 16'h0000, 16'h0000, 16'h0002}, 1'b0, {16'h0001, 16'h0002});
        tbl[6] = mk({32'hFFFFFEFF, 32'hFFFFFF00, 32'h00000100, 32'h000000FF}, 1'b1,
                    {16'hFFFF, 16'h0000, 16'h0001, 16'h0000}, 1'b0, {16'h0000, 16'h0001});
        tbl[7] = mk({32'h00000000, 32'h00000000, 32'hFF000000, 32'h00FFFEFF}, 1'b1,
                    {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 1'b0, {16'h0000, 16'h7FFF});
        tbl[8] = mk({32'h00000000, 32'h00000000, 32'h00000000, 32'h00FFFF00}, 1'b1,
                    {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b1, {16'h0000, 16'h7FFF});
        tbl[9] = mk({32'h00000000, 32'h00000000, 32'h00000000, 32'hFEFFFEFF}, 1'b1,
                    {16'h0000, 16'h0000, 16'h0000, 16'h8000}, 1'b1, {16'h0000, 16'h0000});
        for (int r = 0; r < B; r++) macc[r] = QMIN;

        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Table vectors back to back with no back-pressure: also measures latency and throughput.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_data = tbl[i].din; in_last = tbl[i].last; cur_exp = tbl[i].e;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("latency", 32'(first_fire - first_acc), 32'd2);
        chk("throughput", 32'(last_fire - first_fire), 32'(NV - 1));
        chk("table_beats", 32'(nfire), 32'(NV));

        // Deterministic stall: both stages fill, input is held off, then drains in order.
        use_model = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; in_data = tbl[0].din; out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("stall_drain", 32'(sbq.size()), 32'd0);

        // Random traffic with random back-pressure.
        nacc = 0;
        for (int n = 0; n < 5000 && nacc < 200; n++) begin
            in_valid = $urandom_range(0, 9) < 7;
            for (int k = 0; k < L; k++) in_data[k*WI +: WI] = rand_lane();
            in_last = $urandom_range(0, 2) == 0;
            out_ready = $urandom_range(0, 9) < 6;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 50 && sbq.size() > 0; n++) tick();
        chk("random_accepted", 32'(nacc), 32'd200);
        chk("random_drain", 32'(sbq.size()), 32'd0);

        // Reset with two tiles in flight and a partial row group holding a large max.
        in_valid = 1'b1; in_last = 1'b0;
        in_data = {32'h0, 32'h0, 32'h0, 32'h0000C800};
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        sbq.delete();
        for (int r = 0; r < B; r++) macc[r] = QMIN;
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        use_model = 1'b0;
        in_valid = 1'b1; in_last = 1'b1;
        in_data = {32'hFFFFF200, 32'hFFFFF200, 32'hFFFFF600, 32'hFFFFF600};
        cur_exp.data = {16'hFFF9, 16'hFFF9, 16'hFFFB, 16'hFFFB};
        cur_exp.last = 1'b1; cur_exp.sat = 1'b0; cur_exp.rmax = {16'hFFF9, 16'hFFFB};
        nfire = 0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("post_reset_beats", 32'(nfire), 32'd1);
        chk("post_reset_drain", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/attn_score_requant.md
Name: attn_score_requant

Overview:
- Sits directly downstream of the QK^T block-matmul array in multi-head attention.
- Consumes one BLOCK_SIZE x BLOCK_SIZE tile of wide fixed-point dot products per beat.
- Applies the 1/sqrt(d_k) scale as an arithmetic right shift, rounds, saturates to the output format and forwards the tile to softmax.
- Also tracks the running per-row maximum across a row's column tiles and emits it with the row's last tile, for softmax max-subtraction.

Parameters:
- WIDTH_IN, 32, signed input lane width (TOP_WIDTH_A + TOP_WIDTH_B).
- FRAC_IN, 16, input fractional bits (TOP_FRAC_WIDTH_A + TOP_FRAC_WIDTH_B).
- WIDTH_OUT, 16, signed output lane width (TOP_WIDTH_OUT).
- FRAC_OUT, 8, output fractional bits (TOP_FRAC_WIDTH_OUT).
- BLOCK_SIZE, 2, tile edge; lanes = BLOCK_SIZE*BLOCK_SIZE.
- SCALE_SHIFT, 1, log2(sqrt(d_k)); the default 1 corresponds to d_k = 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input tile valid.
- in_ready  out  1  input tile accepted when in_valid && in_ready.
- in_data  in  BLOCK_SIZE*BLOCK_SIZE*WIDTH_IN  tile, lane k = r*BLOCK_SIZE+c at bits [k*WIDTH_IN +: WIDTH_IN].
- in_last  in  1  tile is the final column tile of its row group.
- out_valid  out  1  output tile valid.
- out_ready  in  1  downstream accept.
- out_data  out  BLOCK_SIZE*BLOCK_SIZE*WIDTH_OUT  requantized tile, same lane order as in_data.
- out_last  out  1  in_last carried through with its tile.
- out_sat  out  1  at least one lane of this tile saturated.
- out_row_max  out  BLOCK_SIZE*WIDTH_OUT  per-row maximum, row r at [r*WIDTH_OUT +: WIDTH_OUT]; meaningful only when out_valid && out_last.

Behaviour:
- Reset: rst_n low asynchronously clears all valids, out_data, out_last, out_sat, out_row_max to 0. Row-max accumulators go to the most negative value (-2^(WIDTH_OUT-1)).
- Reset mid-operation discards in-flight tiles and any partial row max. No output appears until new input arrives after reset.
- Arithmetic, per lane: S = FRAC_IN - FRAC_OUT + SCALE_SHIFT, with S >= 1 (elaboration error otherwise).
  - Compute t = (x + 2^(S-1)) >>> S in WIDTH_IN+1 bits (round half up, no wrap on the add).
  - Saturate t to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]; out_sat is the OR over lanes of the clip condition.
- Pipeline, exactly 2 register stages, latency 2 cycles from accept to out_valid with no stalls:
  - Stage 1 registers the rounded/shifted values.
  - Stage 2 registers the saturated tile, sat flag, last flag and row max.
- Handshake:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 loads when its slot is empty or stage 2 loads.
  - in_ready equals stage-1 load enable (combinational from out_ready is permitted).
  - Full throughput: one tile per cycle while out_ready stays high.
- Stall: while out_valid && !out_ready, out_data, out_last, out_sat and out_row_max hold stable. No beat is lost or duplicated.
- Row max is computed in stage 2 on saturated values. For each row r, out_row_max[r] = max(acc[r], max over c of lane(r,c)).
  - On a stage-2 load with last = 0: acc[r] is updated to that value.
  - On a stage-2 load with last = 1: out_row_max shows the value and acc[r] resets to most negative, so the next tile starts a fresh row group.
  - A single-tile row group (in_last on the first tile) is legal.
- out_row_max is 0 on beats where out_last = 0.
- No internal flow control beyond the 2 stages; no FIFO.

Test Plan:
- Defaults (S=9), lanes {0x00010000, 0x00000200, 0x000002FF, 0x00000300}, in_last=1 -> after 2 cycles out_data lanes {0x0080, 0x0001, 0x0001, 0x0002}, out_sat=0, out_row_max = {row0 0x0080, row1 0x0002}.
- Lanes {0x01000000, 0x80000000, 0xFFFFFD00, 0x0} -> {0x7FFF, 0x8000, 0xFFFF, 0x0000}, out_sat=1.
- Row group of 3 tiles, row0 lane values 5, 9, 3 (output units) in successive beats, in_last on the third -> out_row_max row0 = 9 on the third beat only. A following single tile with row0 = 2 and last=1 gives row max 2 (accumulator reset).
- Random out_ready back-pressure over 200 random tiles -> scoreboard matches order and values exactly; outputs stable during every stall; in_ready low only when both stages are full and out_ready is low.
- Continuous in_valid with out_ready=1 -> one out_valid per cycle, first at cycle 2 after the first accept.
- Assert rst_n low for 1 cycle with 2 tiles in flight and a partial row group -> out_valid drops immediately. The next row group's max ignores pre-reset data.
